mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have ports: clk  in  1  clock, all state updates on rising edge.
REQ-002 SHALL have ports: rst  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have ports: reqValid  in  1  request present; reqReady  out  1  unit can accept a request.
REQ-004 SHALL have ports: reqWrite  in  1  1=store, 0=load; reqSize  in  2  00 byte, 01 half, 10 word, 11 treated as word.
REQ-005 SHALL have ports: reqUnsigned  in  1  zero-extend loads; reqAdr  in  32  byte address; reqWData  in  32  store data, LSB-justified.
REQ-006 SHALL have ports: respValid  out  1  one-cycle completion pulse; respRData  out  32  load result; respErr  out  1  misaligned access.
REQ-007 SHALL have ports: memAdr  out  32  word-aligned memory address; memWriteData  out  32  full word to write; memWrite  out  1  write strobe; memReadData  in  32  combinational read word.

Function
REQ-008 SHALL treat memory as word-only write, combinational read; byte at offset k occupies memory word bits [31-8k:24-8k]; half at offset 0 is [31:16], offset 2 is [15:0].
REQ-009 SHALL implement FSM states IDLE, RD, WR, RESP; reqReady=1 only in IDLE; request accepted on reqValid&reqReady at a rising edge, latching adr/size/unsigned/write/data.
REQ-010 SHALL transition: load IDLE->RD->RESP; word store IDLE->WR->RESP; byte/half store IDLE->RD->WR->RESP; RESP->IDLE unconditionally.
REQ-011 SHALL drive memAdr={adr[31:2],2'b00} in RD and WR, 0 otherwise; memWrite=1 only in WR, exactly one cycle per store.
REQ-012 SHALL capture memReadData into an internal word register at the end of RD.
REQ-013 SHALL, for byte/half stores, set memWriteData to the captured word with only the addressed lane(s) replaced by reqWData[7:0]/[15:0]; word store writes reqWData unchanged.
REQ-014 SHALL, for loads, extract the addressed lane and sign-extend (reqUnsigned=0) or zero-extend (reqUnsigned=1); word loads return the word unchanged.
REQ-015 SHALL assert respValid for exactly the RESP cycle, holding respRData and respErr stable that cycle; respRData=0 for stores.
REQ-016 SHALL give latency from accept edge to respValid: load 2 cycles, word store 2, sub-word store 3; throughput one request per RESP->IDLE return.
REQ-017 SHALL ignore reqValid while not in IDLE; latched request fields SHALL not change mid-operation.

Reset
REQ-018 SHALL on rst=0 immediately force state IDLE, memWrite=0, respValid=0, respErr=0, respRData=0, memAdr=0, internal registers 0, reqReady=1, including mid-RD or mid-WR; no partial write completes.

Configuration
REQ-019 SHALL, with MISALIGN_TRAP_EN defined, detect half with adr[0]=1 or word with adr[1:0]!=0, go IDLE->RESP with respErr=1, respRData=0, no memory access.
REQ-020 SHALL, without MISALIGN_TRAP_EN, tie respErr=0 and ignore offending low bits (half uses adr[1] only, word uses offset 0).

Structure
REQ-021 SHALL place size encodings (SIZE_BYTE/HALF/WORD) and the FSM state enum in shared package mem_access_pkg.
REQ-022 SHALL put lane extraction/merge in one combinational sub-module byte_lane_unit; FSM and registers remain in mem_access_unit.

Verification
REQ-023 SHALL cover: word 0x11A23344 at 0x100; lb 0x101 -> respRData 0xFFFFFFA2; lbu 0x101 -> 0x000000A2; respValid 2 cycles after accept.
REQ-024 SHALL cover: lhu 0x102 on same word -> 0x00003344; lh 0x100 -> 0x000011A2.
REQ-025 SHALL cover: sb 0x102 data 0x000000EE -> single memWrite cycle with memWriteData 0x11A2EE44 at memAdr 0x100, respValid 3 cycles after accept.
REQ-026 SHALL cover: sw 0x104 data 0xDEADBEEF -> no RD state, memWrite 1 cycle after accept, readback lw 0x104 -> 0xDEADBEEF.
REQ-027 SHALL cover: lw 0x102 -> with MISALIGN_TRAP_EN respErr=1, no memWrite, respValid 1 cycle after accept; without macro returns word at 0x100, respErr=0.
REQ-028 SHALL cover: rst driven low during WR of sb -> memWrite falls immediately, memory unchanged, reqReady=1 after release.

Source files
------------

// File: rtl/mem_access_pkg.sv
// Shared definitions for the memory access unit: access size encodings and FSM states.
package mem_access_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        RESP = 2'd3
    } state_t;

    // Both 2'b10 and 2'b11 are whole-word accesses.
    function automatic logic isWordSize(input logic [1:0] size);
        return size[1];
    endfunction

endpackage

// File: rtl/byte_lane_unit.sv
// Combinational lane logic: extracts a load lane from a memory word and merges store data
// into a memory word. Byte at offset k lives in bits [31-8k:24-8k] (big-endian lanes).
module byte_lane_unit
    import mem_access_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        isUnsigned,
    input  logic [31:0] wData,
    output logic [31:0] rData,
    output logic [31:0] mergedWord
);

    logic [7:0]  byteSel;
    logic [15:0] halfSel;

    always_comb begin
        byteSel    = '0;
        halfSel    = offset[1] ? word[15:0] : word[31:16];
        rData      = word;
        mergedWord = wData;

        case (offset)
            2'd0:    byteSel = word[31:24];
            2'd1:    byteSel = word[23:16];
            2'd2:    byteSel = word[15:8];
            default: byteSel = word[7:0];
        endcase

        case (size)
            SIZE_BYTE: begin
                rData      = isUnsigned ? {24'd0, byteSel} : {{24{byteSel[7]}}, byteSel};
                mergedWord = word;
                case (offset)
                    2'd0:    mergedWord[31:24] = wData[7:0];
                    2'd1:    mergedWord[23:16] = wData[7:0];
                    2'd2:    mergedWord[15:8]  = wData[7:0];
                    default: mergedWord[7:0]   = wData[7:0];
                endcase
            end
            SIZE_HALF: begin
                rData      = isUnsigned ? {16'd0, halfSel} : {{16{halfSel[15]}}, halfSel};
                mergedWord = word;
                if (offset[1]) mergedWord[15:0]  = wData[15:0];
                else           mergedWord[31:16] = wData[15:0];
            end
            default: begin
                rData      = word;
                mergedWord = wData;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit over a word-only-write, combinational-read memory; sub-word stores use
// read-modify-write. Define MISALIGN_TRAP_EN to trap misaligned half/word accesses.
module mem_access_unit
    import mem_access_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        reqValid,
    output logic        reqReady,
    input  logic        reqWrite,
    input  logic [1:0]  reqSize,
    input  logic        reqUnsigned,
    input  logic [31:0] reqAdr,
    input  logic [31:0] reqWData,
    output logic        respValid,
    output logic [31:0] respRData,
    output logic        respErr,
    output logic [31:0] memAdr,
    output logic [31:0] memWriteData,
    output logic        memWrite,
    input  logic [31:0] memReadData
);

    state_t      state;
    logic [1:0]  adrLow;
    logic [1:0]  sizeReg;
    logic        unsReg;
    logic        writeReg;
    logic [31:0] wDataReg;
    logic [31:0] wordReg;
    logic        misalign;
    logic [31:0] laneRData;
    logic [31:0] laneMerged;

`ifdef MISALIGN_TRAP_EN
    always_comb begin
        misalign = ((reqSize == SIZE_HALF) && reqAdr[0]) ||
                   (isWordSize(reqSize) && (reqAdr[1:0] != 2'b00));
    end
`else
    always_comb begin
        misalign = 1'b0;
    end
`endif

    byte_lane_unit uLane (
        .word       (wordReg),
        .offset     (adrLow),
        .size       (sizeReg),
        .isUnsigned (unsReg),
        .wData      (wDataReg),
        .rData      (laneRData),
        .mergedWord (laneMerged)
    );

    assign reqReady = (state == IDLE);
    // Data outputs decode registered state only, so they are stable for the whole cycle.
    assign memWriteData = (state == WR) ? laneMerged : '0;
    assign respRData    = (respValid && !writeReg && !respErr) ? laneRData : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            adrLow    <= '0;
            sizeReg   <= '0;
            unsReg    <= 1'b0;
            writeReg  <= 1'b0;
            wDataReg  <= '0;
            wordReg   <= '0;
            memAdr    <= '0;
            memWrite  <= 1'b0;
            respValid <= 1'b0;
            respErr   <= 1'b0;
        end else begin
            memWrite  <= 1'b0;
            respValid <= 1'b0;
            respErr   <= 1'b0;
            case (state)
                IDLE: begin
                    if (reqValid) begin
                        adrLow   <= reqAdr[1:0];
                        sizeReg  <= reqSize;
                        unsReg   <= reqUnsigned;
                        writeReg <= reqWrite;
                        wDataReg <= reqWData;
                        if (misalign) begin
                            state     <= RESP;
                            respValid <= 1'b1;
                            respErr   <= 1'b1;
                        end else if (reqWrite && isWordSize(reqSize)) begin
                            state    <= WR;
                            memAdr   <= {reqAdr[31:2], 2'b00};
                            memWrite <= 1'b1;
                        end else begin
                            state  <= RD;
                            memAdr <= {reqAdr[31:2], 2'b00};
                        end
                    end
                end
                RD: begin
                    wordReg <= memReadData;
                    if (writeReg) begin
                        state    <= WR;
                        memWrite <= 1'b1;
                    end else begin
                        state     <= RESP;
                        respValid <= 1'b1;
                        memAdr    <= '0;
                    end
                end
                WR: begin
                    state     <= RESP;
                    respValid <= 1'b1;
                    memAdr    <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed vector table plus busy-ignore and reset-in-WR sequences.
module tb_mem_access_unit;
    import mem_access_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        reqValid = 1'b0;
    logic        reqReady;
    logic        reqWrite = 1'b0;
    logic [1:0]  reqSize = 2'b00;
    logic        reqUnsigned = 1'b0;
    logic [31:0] reqAdr = '0;
    logic [31:0] reqWData = '0;
    logic        respValid;
    logic [31:0] respRData;
    logic        respErr;
    logic [31:0] memAdr;
    logic [31:0] memWriteData;
    logic        memWrite;
    logic [31:0] memReadData;

    logic [31:0] mem [0:255];
    int nTests = 0;
    int nFail  = 0;

    mem_access_unit dut (
        .clk(clk), .rst(rst), .reqValid(reqValid), .reqReady(reqReady),
        .reqWrite(reqWrite), .reqSize(reqSize), .reqUnsigned(reqUnsigned),
        .reqAdr(reqAdr), .reqWData(reqWData), .respValid(respValid),
        .respRData(respRData), .respErr(respErr), .memAdr(memAdr),
        .memWriteData(memWriteData), .memWrite(memWrite), .memReadData(memReadData)
    );

    always #5 clk = ~clk;

    assign memReadData = mem[memAdr[9:2]];
    always @(posedge clk) if (memWrite) mem[memAdr[9:2]] <= memWriteData;

    typedef struct {
        logic        wr;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] adr;
        logic [31:0] wdata;
        logic [31:0] expR;
        logic        expErr;
        int          expLat;
        int          expNW;
        int          expWCyc;
        logic [31:0] expWAdr;
        logic [31:0] expWData;
    } vec_t;

    function automatic vec_t mk(logic wr, logic [1:0] size, logic uns, logic [31:0] adr,
                                logic [31:0] wdata, logic [31:0] expR, logic expErr, int expLat,
                                int expNW, int expWCyc, logic [31:0] expWAdr, logic [31:0] expWData);
        vec_t v;
        v.wr = wr; v.size = size; v.uns = uns; v.adr = adr; v.wdata = wdata;
        v.expR = expR; v.expErr = expErr; v.expLat = expLat; v.expNW = expNW;
        v.expWCyc = expWCyc; v.expWAdr = expWAdr; v.expWData = expWData;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic runReq(input logic wr, input logic [1:0] size, input logic uns,
                          input logic [31:0] adr, input logic [31:0] wdata,
                          output int lat, output logic [31:0] rdata, output logic err,
                          output int nW, output int wCyc, output logic [31:0] wAdr,
                          output logic [31:0] wData);
        bit done;
        lat = 0; rdata = '0; err = 1'b0; nW = 0; wCyc = 0; wAdr = '0; wData = '0; done = 0;
        @(negedge clk);
        chk("reqReady_idle", {31'd0, reqReady}, 32'd1);
        reqWrite = wr; reqSize = size; reqUnsigned = uns; reqAdr = adr; reqWData = wdata;
        reqValid = 1'b1;
        @(posedge clk);
        #1 reqValid = 1'b0;
        for (int c = 1; c <= 8 && !done; c++) begin
            @(negedge clk);
            if (memWrite) begin
                nW++; wCyc = c; wAdr = memAdr; wData = memWriteData;
            end
            if (respValid) begin
                lat = c; rdata = respRData; err = respErr; done = 1;
            end
        end
    endtask

    vec_t vecs[16];
    int lat, nW, wCyc;
    logic [31:0] rdata, wAdr, wData;
    logic err;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        mem[8'h40] = 32'h11A23344;

`ifdef MISALIGN_TRAP_EN
        vecs[13] = mk(0, SIZE_WORD, 0, 32'h102, 0, 32'h0,        1, 1, 0, 0, 0, 0);
        vecs[14] = mk(1, SIZE_HALF, 0, 32'h101, 32'hCAFE, 32'h0, 1, 1, 0, 0, 0, 0);
        vecs[15] = mk(0, SIZE_WORD, 0, 32'h100, 0, 32'h11A2EE44, 0, 2, 0, 0, 0, 0);
`else
        vecs[13] = mk(0, SIZE_WORD, 0, 32'h102, 0, 32'h11A2EE44, 0, 2, 0, 0, 0, 0);
        vecs[14] = mk(1, SIZE_HALF, 0, 32'h101, 32'hCAFE, 32'h0, 0, 3, 1, 2, 32'h100, 32'hCAFEEE44);
        vecs[15] = mk(0, SIZE_WORD, 0, 32'h100, 0, 32'hCAFEEE44, 0, 2, 0, 0, 0, 0);
`endif
        vecs[0]  = mk(0, SIZE_BYTE, 0, 32'h101, 0, 32'hFFFFFFA2, 0, 2, 0, 0, 0, 0);
        vecs[1]  = mk(0, SIZE_BYTE, 1, 32'h101, 0, 32'h000000A2, 0, 2, 0, 0, 0, 0);
        vecs[2]  = mk(0, SIZE_HALF, 1, 32'h102, 0, 32'h00003344, 0, 2, 0, 0, 0, 0);
        vecs[3]  = mk(0, SIZE_HALF, 0, 32'h100, 0, 32'h000011A2, 0, 2, 0, 0, 0, 0);
        vecs[4]  = mk(1, SIZE_BYTE, 0, 32'h102, 32'hEE, 32'h0, 0, 3, 1, 2, 32'h100, 32'h11A2EE44);
        vecs[5]  = mk(0, SIZE_BYTE, 0, 32'h102, 0, 32'hFFFFFFEE, 0, 2, 0, 0, 0, 0);
        vecs[6]  = mk(1, SIZE_WORD, 0, 32'h104, 32'hDEADBEEF, 32'h0, 0, 2, 1, 1, 32'h104, 32'hDEADBEEF);
        vecs[7]  = mk(0, SIZE_WORD, 0, 32'h104, 0, 32'hDEADBEEF, 0, 2, 0, 0, 0, 0);
        vecs[8]  = mk(0, SIZE_HALF, 0, 32'h104, 0, 32'hFFFFDEAD, 0, 2, 0, 0, 0, 0);
        vecs[9]  = mk(0, SIZE_HALF, 1, 32'h106, 0, 32'h0000BEEF, 0, 2, 0, 0, 0, 0);
        vecs[10] = mk(0, SIZE_BYTE, 0, 32'h107, 0, 32'hFFFFFFEF, 0, 2, 0, 0, 0, 0);
        vecs[11] = mk(1, SIZE_HALF, 0, 32'h106, 32'h12345678, 32'h0, 0, 3, 1, 2, 32'h104, 32'hDEAD5678);
        vecs[12] = mk(0, 2'b11,     0, 32'h104, 0, 32'hDEAD5678, 0, 2, 0, 0, 0, 0);

        // Reset state, sampled while reset is held.
        #1;
        chk("rst_reqReady",  {31'd0, reqReady},  32'd1);
        chk("rst_respValid", {31'd0, respValid}, 32'd0);
        chk("rst_memWrite",  {31'd0, memWrite},  32'd0);
        chk("rst_respErr",   {31'd0, respErr},   32'd0);
        chk("rst_memAdr",    memAdr,             32'd0);
        chk("rst_respRData", respRData,          32'd0);
        @(negedge clk); @(negedge clk);
        rst = 1'b1;

        foreach (vecs[i]) begin
            runReq(vecs[i].wr, vecs[i].size, vecs[i].uns, vecs[i].adr, vecs[i].wdata,
                   lat, rdata, err, nW, wCyc, wAdr, wData);
            chk($sformatf("v%0d_lat", i),   lat,             vecs[i].expLat);
            chk($sformatf("v%0d_rdata", i), rdata,           vecs[i].expR);
            chk($sformatf("v%0d_err", i),   {31'd0, err},    {31'd0, vecs[i].expErr});
            chk($sformatf("v%0d_nwr", i),   nW,              vecs[i].expNW);
            if (vecs[i].expNW != 0) begin
                chk($sformatf("v%0d_wcyc", i),  wCyc,  vecs[i].expWCyc);
                chk($sformatf("v%0d_wadr", i),  wAdr,  vecs[i].expWAdr);
                chk($sformatf("v%0d_wdata", i), wData, vecs[i].expWData);
            end
        end

        // reqValid held high with changing fields while busy must be ignored.
        begin
            bit done;
            int c;
            done = 0; c = 0;
            @(negedge clk);
            reqWrite = 1'b0; reqSize = SIZE_BYTE; reqUnsigned = 1'b0; reqAdr = 32'h107;
            reqValid = 1'b1;
            @(posedge clk);
            #1 reqAdr = 32'h100; reqSize = SIZE_WORD;
            while (!done && c < 8) begin
                @(negedge clk);
                c++;
                if (respValid) begin
                    done = 1;
                    reqValid = 1'b0;
                    chk("busy_lat",   c,         2);
                    chk("busy_rdata", respRData, 32'h00000078);
                end else begin
                    chk("busy_ready", {31'd0, reqReady}, 32'd0);
                end
            end
            if (!done) chk("busy_timeout", 32'd0, 32'd1);
        end

        // Asynchronous reset during WR of a byte store.
        @(negedge clk);
        reqWrite = 1'b1; reqSize = SIZE_BYTE; reqUnsigned = 1'b0; reqAdr = 32'h105; reqWData = 32'h55;
        reqValid = 1'b1;
        @(posedge clk);
        #1 reqValid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rstwr_memWrite_before", {31'd0, memWrite}, 32'd1);
        rst = 1'b0;
        #1;
        chk("rstwr_memWrite_after", {31'd0, memWrite}, 32'd0);
        chk("rstwr_memAdr",         memAdr,            32'd0);
        chk("rstwr_memWriteData",   memWriteData,      32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rstwr_mem_unchanged", mem[8'h41], 32'hDEAD5678);
        chk("rstwr_reqReady",      {31'd0, reqReady}, 32'd1);

        runReq(0, SIZE_WORD, 0, 32'h104, 0, lat, rdata, err, nW, wCyc, wAdr, wData);
        chk("post_rst_lw_rdata", rdata, 32'hDEAD5678);
        chk("post_rst_lw_lat",   lat,   2);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
